video_frame_signature: RTL and testbench
========================================

Name: video_frame_signature

Overview:
- Passive per-frame checker that computes a CRC-32 signature over all active pixels of each video frame.
- It also counts active pixels and lines and checks them against the expected raster geometry.
- It sits on the pixel-clock side of the HDMI text controller, tapped off the VGA timing outputs and the draw-logic RGB.
- Hardware frame signatures are compared against simulated frame dumps. It generalises fixed 3x4-bit RGB capture to any channel count and width.

Parameters:
- NUM_CH, 3, number of colour channels.
- CH_W, 4, bits per channel.
- H_ACTIVE, 640, expected active pixels per line.
- V_ACTIVE, 480, expected active lines per frame.
- VS_ACTIVE_LOW, 1, 1 = pixel_vs asserts low, 0 = asserts high.
- CNT_W, 20, width of the pixel and line counters (must hold H_ACTIVE*V_ACTIVE).

Ports:
- pixel_clk  in  1  pixel clock.
- arstn  in  1  reset; synchronous, active-low, clocked by pixel_clk.
- enable  in  1  1 = capture; 0 = idle and disarmed.
- pixel_rgb  in  NUM_CH*CH_W  channel 0 in the MSBs (channel 0 = red).
- pixel_vde  in  1  active-video qualifier.
- pixel_vs  in  1  vertical sync, polarity set by VS_ACTIVE_LOW.
- sig_ack  in  1  consumer acknowledges the current result.
- sig_valid  out  1  result registers hold an unacknowledged frame result.
- sig_crc  out  32  final CRC of the last completed frame.
- sig_pix_count  out  CNT_W  active pixels in the last frame.
- sig_line_count  out  CNT_W  active lines in the last frame.
- sig_geom_err  out  1  last frame had at least one line length different from H_ACTIVE, or a line count different from V_ACTIVE.
- sig_overrun  out  1  sticky: a result was overwritten before it was acknowledged.
- frame_count  out  16  completed frames since reset; wraps from 0xFFFF to 0.

Behaviour:
- Reset (arstn=0 sampled on a pixel_clk edge):
  - All outputs go to 0.
  - The accumulator is set to 0xFFFFFFFF.
  - The module is disarmed.
  - vs_q is set to the inactive level.
- Frame edge: the cycle where pixel_vs is at its active level and vs_q is inactive. vs_q is pixel_vs registered every cycle.
- States:
  - IDLE: entered on reset or when enable=0. Leaves when enable=1.
  - ARMING: waits for the first frame edge. That edge produces no result.
  - CAPTURE: accumulates the frame. Each later frame edge closes the frame.
  - enable=0 from any state returns to IDLE next cycle and discards the partial frame. Already-latched outputs are kept.
- CRC:
  - Polynomial 0x04C11DB7, non-reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - One pixel per cycle when pixel_vde=1 in CAPTURE. All NUM_CH*CH_W bits are shifted in MSB first.
  - The update is a single-cycle combinational unroll.
- Counters:
  - The pixel counter increments on every vde pixel.
  - The line counter increments on each rising edge of pixel_vde.
  - On each falling edge of pixel_vde, if the per-line count is not H_ACTIVE, a per-frame error flag is set.
- Frame close (frame edge seen in CAPTURE at cycle N), registered at the end of N so results are visible in N+1:
  - sig_crc, the counts and sig_geom_err are latched. sig_geom_err = line_err OR (line count != V_ACTIVE).
  - sig_valid=1 and frame_count increments.
  - The accumulator, counters and error flag are reinitialised.
- Same-cycle pixel at the frame edge: a pixel with pixel_vde=1 in the frame-edge cycle belongs to the new frame. The accumulator restarts from init and includes that pixel.
- Handshake:
  - sig_valid stays 1 until sig_ack=1 is sampled, then clears next cycle.
  - sig_ack while sig_valid=0 is ignored.
- Overrun: a frame close while sig_valid=1 and sig_ack=0 overwrites the outputs and sets sig_overrun. sig_overrun clears only on reset.
- Close and ack in the same cycle: the new result wins, sig_valid stays 1, and no overrun is flagged.
- Reset mid-frame aborts everything; the next frame edge only re-arms.
- Counter saturation: counters saturate at all-ones and force sig_geom_err.

Optional Feature:
- Macro: VIDEO_FRAME_SIGNATURE_COMPARE_EN.
- With the macro defined:
  - Adds input exp_crc (32) and output sig_match (1).
  - sig_match is registered at frame close as (final CRC == exp_crc sampled that cycle).
  - sig_match resets to 0.
- Without the macro: neither port exists and no comparator logic is built.

Test Plan:
- Bench parameters: NUM_CH=3, CH_W=4, H_ACTIVE=4, V_ACTIVE=2, VS_ACTIVE_LOW=1.
- Scenarios:
  - Reset held 4 cycles, then one frame of 2 lines x 4 pixels of 12'hFFF between vs edges -> no sig_valid after the first (arming) edge. After the second edge: sig_valid=1, pix_count=8, line_count=2, geom_err=0, frame_count=1, and sig_crc equals the bench model CRC over eight 12-bit 0xFFF words.
  - Pixel values 0..7 ascending -> sig_crc equals the model value and differs from scenario 1. Repeating the identical frame gives an identical CRC.
  - Second line only 3 pixels -> pix_count=7, geom_err=1. The next clean frame gives geom_err=0.
  - Two frames closed with no sig_ack -> second result visible, sig_overrun=1, frame_count=2. sig_ack then clears sig_valid within 1 cycle while sig_overrun stays 1.
  - sig_ack asserted in the exact frame-close cycle -> sig_valid stays 1, sig_overrun stays 0. In a separate frame, vde=1 on the frame-edge cycle -> that pixel is counted in the new frame (pix_count=8 with 7 later pixels).
  - arstn=0 mid-frame -> all outputs 0. The next vs edge yields no result, and the one after yields a correct full frame.
  - With VIDEO_FRAME_SIGNATURE_COMPARE_EN defined: exp_crc set to the model value -> sig_match=1; exp_crc with bit 0 flipped -> sig_match=0.

Source files
------------

// File: rtl/video_frame_signature.sv
// video_frame_signature
// Passive per-frame checker on the pixel-clock side of the video path. Each
// frame gets a CRC-32 signature over its active pixels, plus pixel and line
// counts that are checked against the expected raster geometry.
//
// Optional feature: define VIDEO_FRAME_SIGNATURE_COMPARE_EN to add exp_crc
// and sig_match, a registered compare of the final CRC at frame close.
//
// Ports:
//   pixel_clk       pixel clock
//   arstn           synchronous active-low reset
//   enable          1 = capture, 0 = idle and disarmed
//   pixel_rgb       NUM_CH*CH_W pixel word, channel 0 (red) in the MSBs
//   pixel_vde       active-video qualifier
//   pixel_vs        vertical sync, polarity from VS_ACTIVE_LOW
//   sig_ack         consumer acknowledges the current result
//   exp_crc         (optional) expected CRC for the closing frame
//   sig_match       (optional) last frame CRC equalled exp_crc
//   sig_valid       result registers hold an unacknowledged result
//   sig_crc         final CRC of the last completed frame
//   sig_pix_count   active pixels in the last frame
//   sig_line_count  active lines in the last frame
//   sig_geom_err    last frame had a bad line length or line count
//   sig_overrun     sticky: a result was overwritten before acknowledge
//   frame_count     completed frames since reset, wrapping
module video_frame_signature #(
  parameter int NUM_CH        = 3,
  parameter int CH_W          = 4,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int CNT_W         = 20
) (
  input  logic                     pixel_clk,
  input  logic                     arstn,
  input  logic                     enable,
  input  logic [NUM_CH*CH_W-1:0]   pixel_rgb,
  input  logic                     pixel_vde,
  input  logic                     pixel_vs,
  input  logic                     sig_ack,
`ifdef VIDEO_FRAME_SIGNATURE_COMPARE_EN
  input  logic [31:0]              exp_crc,
  output logic                     sig_match,
`endif
  output logic                     sig_valid,
  output logic [31:0]              sig_crc,
  output logic [CNT_W-1:0]         sig_pix_count,
  output logic [CNT_W-1:0]         sig_line_count,
  output logic                     sig_geom_err,
  output logic                     sig_overrun,
  output logic [15:0]              frame_count
);

  localparam int              PIX_W       = NUM_CH * CH_W;
  localparam logic [31:0]     CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0]     CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] H_EXP      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXP      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic            VS_INACTIVE = (VS_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state;
  logic             vs_q;
  logic             vde_q;
  logic [31:0]      crc_acc;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] line_pix;
  logic             line_err;

  // Non-reflected MSB-first CRC-32 over one whole pixel word, unrolled so a
  // full pixel is absorbed every clock.
  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic [PIX_W-1:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = PIX_W - 1; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  logic             vs_act;
  logic             vs_q_act;
  logic             frame_edge;
  logic             vde_rise;
  logic             vde_fall;
  logic [31:0]      crc_fresh;
  logic [31:0]      crc_upd;
  logic [CNT_W-1:0] start_cnt;
  logic             close_geom;

  // Edge detection and the two CRC paths: crc_fresh restarts the signature
  // for a new frame, so a pixel landing on the frame-edge cycle belongs to
  // the frame being opened rather than the one being closed.
  always_comb begin
    vs_act     = (pixel_vs != VS_INACTIVE);
    vs_q_act   = (vs_q != VS_INACTIVE);
    frame_edge = vs_act & ~vs_q_act;
    vde_rise   = pixel_vde & ~vde_q;
    vde_fall   = ~pixel_vde & vde_q;
    crc_fresh  = pixel_vde ? crc_step(CRC_INIT, pixel_rgb) : CRC_INIT;
    crc_upd    = pixel_vde ? crc_step(crc_acc, pixel_rgb) : crc_acc;
    start_cnt  = pixel_vde ? CNT_ONE : '0;
    close_geom = line_err
               | (vde_fall && (line_pix != H_EXP))
               | (line_cnt != V_EXP)
               | (pix_cnt == CNT_MAX)
               | (line_cnt == CNT_MAX);
  end

  // Control FSM, accumulators and result registers. Dropping enable always
  // wins and throws away the partial frame but keeps the latched results.
  // A close in the same cycle as an acknowledge keeps sig_valid high because
  // the later nonblocking write takes precedence.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state          <= IDLE;
      vs_q           <= VS_INACTIVE;
      vde_q          <= 1'b0;
      crc_acc        <= CRC_INIT;
      pix_cnt        <= '0;
      line_cnt       <= '0;
      line_pix       <= '0;
      line_err       <= 1'b0;
      sig_valid      <= 1'b0;
      sig_crc        <= '0;
      sig_pix_count  <= '0;
      sig_line_count <= '0;
      sig_geom_err   <= 1'b0;
      sig_overrun    <= 1'b0;
      frame_count    <= '0;
`ifdef VIDEO_FRAME_SIGNATURE_COMPARE_EN
      sig_match      <= 1'b0;
`endif
    end else begin
      vs_q  <= pixel_vs;
      vde_q <= pixel_vde;
      if (sig_ack) sig_valid <= 1'b0;

      if (!enable) begin
        state    <= IDLE;
        crc_acc  <= CRC_INIT;
        pix_cnt  <= '0;
        line_cnt <= '0;
        line_pix <= '0;
        line_err <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARMING;
          ARMING: begin
            if (frame_edge) begin
              state    <= CAPTURE;
              crc_acc  <= crc_fresh;
              pix_cnt  <= start_cnt;
              line_cnt <= start_cnt;
              line_pix <= start_cnt;
              line_err <= 1'b0;
            end
          end
          CAPTURE: begin
            if (frame_edge) begin
              sig_crc        <= ~crc_acc;
              sig_pix_count  <= pix_cnt;
              sig_line_count <= line_cnt;
              sig_geom_err   <= close_geom;
              sig_valid      <= 1'b1;
              if (sig_valid && !sig_ack) sig_overrun <= 1'b1;
              frame_count    <= frame_count + 16'd1;
`ifdef VIDEO_FRAME_SIGNATURE_COMPARE_EN
              sig_match      <= (~crc_acc == exp_crc);
`endif
              crc_acc  <= crc_fresh;
              pix_cnt  <= start_cnt;
              line_cnt <= start_cnt;
              line_pix <= start_cnt;
              line_err <= 1'b0;
            end else begin
              crc_acc <= crc_upd;
              if (pixel_vde && pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_ONE;
              if (vde_rise && line_cnt != CNT_MAX) line_cnt <= line_cnt + CNT_ONE;
              if (vde_rise) line_pix <= CNT_ONE;
              else if (pixel_vde && line_pix != CNT_MAX) line_pix <= line_pix + CNT_ONE;
              if (vde_fall && line_pix != H_EXP) line_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_frame_signature.sv
// tb_video_frame_signature
// Self-checking bench for video_frame_signature with a tiny 4x2 raster.
// A frame-level reference model (pixel list, line-length list) predicts the
// outputs; a vector table drives the main frames and hand-written sequences
// cover acknowledge/overrun, edge pixels, enable drop and mid-frame reset.
module tb_video_frame_signature;

  localparam int NUM_CH   = 3;
  localparam int CH_W     = 4;
  localparam int H_ACTIVE = 4;
  localparam int V_ACTIVE = 2;
  localparam int CNT_W    = 20;

  logic        pixel_clk = 1'b0;
  logic        arstn;
  logic        enable;
  logic [11:0] pixel_rgb;
  logic        pixel_vde;
  logic        pixel_vs;
  logic        sig_ack;
  logic [31:0] exp_crc_v;
  logic        sig_valid;
  logic [31:0] sig_crc;
  logic [CNT_W-1:0] sig_pix_count;
  logic [CNT_W-1:0] sig_line_count;
  logic        sig_geom_err;
  logic        sig_overrun;
  logic [15:0] frame_count;
`ifdef VIDEO_FRAME_SIGNATURE_COMPARE_EN
  logic        sig_match;
`endif

  int checks = 0;
  int errors = 0;

  always #5 pixel_clk = ~pixel_clk;

  video_frame_signature #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .VS_ACTIVE_LOW(1), .CNT_W(CNT_W)
  ) dut (
    .pixel_clk(pixel_clk),
    .arstn(arstn),
    .enable(enable),
    .pixel_rgb(pixel_rgb),
    .pixel_vde(pixel_vde),
    .pixel_vs(pixel_vs),
    .sig_ack(sig_ack),
`ifdef VIDEO_FRAME_SIGNATURE_COMPARE_EN
    .exp_crc(exp_crc_v),
    .sig_match(sig_match),
`endif
    .sig_valid(sig_valid),
    .sig_crc(sig_crc),
    .sig_pix_count(sig_pix_count),
    .sig_line_count(sig_line_count),
    .sig_geom_err(sig_geom_err),
    .sig_overrun(sig_overrun),
    .frame_count(frame_count)
  );

  // Reference model: frame-level view of what the checker should report.
  bit          m_armed, m_cap, m_vs_prev_act, m_vde_prev;
  logic [11:0] m_pix[$];
  int          m_lines[$];
  bit          e_valid, e_geom, e_overrun, e_match;
  logic [31:0] e_crc;
  int          e_pix, e_lines;
  logic [15:0] e_fc;

  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    bit          top;
    c = 32'hFFFFFFFF;
    foreach (m_pix[k]) begin
      for (int b = 11; b >= 0; b--) begin
        top = c[31] ^ m_pix[k][b];
        c = c << 1;
        if (top) c = c ^ 32'h04C11DB7;
      end
    end
    return ~c;
  endfunction

  function automatic void model_start(input logic vde, input logic [11:0] rgb);
    m_pix.delete();
    m_lines.delete();
    if (vde) begin
      m_pix.push_back(rgb);
      m_lines.push_back(1);
    end
  endfunction

  function automatic void model_close(input logic ack, input logic [31:0] exp);
    bit g;
    g = (m_lines.size() != V_ACTIVE);
    foreach (m_lines[i]) if (m_lines[i] != H_ACTIVE) g = 1'b1;
    e_crc   = model_crc();
    e_pix   = m_pix.size();
    e_lines = m_lines.size();
    e_geom  = g;
    if (e_valid && !ack) e_overrun = 1'b1;
    e_valid = 1'b1;
    e_fc    = e_fc + 16'd1;
    e_match = (e_crc == exp);
  endfunction

  function automatic void model_step(input bit rst, input bit en, input logic vs,
                                     input logic vde, input logic [11:0] rgb,
                                     input logic ack, input logic [31:0] exp);
    bit vs_act, edge_seen, closed;
    if (rst) begin
      m_armed = 0; m_cap = 0; m_vs_prev_act = 0; m_vde_prev = 0;
      m_pix.delete(); m_lines.delete();
      e_valid = 0; e_crc = 0; e_pix = 0; e_lines = 0; e_geom = 0;
      e_overrun = 0; e_fc = 0; e_match = 0;
      return;
    end
    vs_act    = !vs;
    edge_seen = vs_act && !m_vs_prev_act;
    closed    = 0;
    if (!en) begin
      m_armed = 0;
      m_cap   = 0;
    end else if (!m_armed && !m_cap) begin
      m_armed = 1;
    end else if (m_armed) begin
      if (edge_seen) begin
        m_armed = 0;
        m_cap   = 1;
        model_start(vde, rgb);
      end
    end else if (edge_seen) begin
      closed = 1;
      model_close(ack, exp);
      model_start(vde, rgb);
    end else if (vde) begin
      if (!m_vde_prev || m_lines.size() == 0) m_lines.push_back(1);
      else m_lines[m_lines.size()-1] = m_lines[m_lines.size()-1] + 1;
      m_pix.push_back(rgb);
    end
    if (ack && !closed) e_valid = 0;
    m_vs_prev_act = vs_act;
    m_vde_prev    = vde;
  endfunction

  // Drive one cycle, let the model see the same inputs, sample after the edge.
  task automatic apply_stimulus(input logic vs, input logic vde,
                                input logic [11:0] rgb, input logic ack);
    pixel_vs  = vs;
    pixel_vde = vde;
    pixel_rgb = rgb;
    sig_ack   = ack;
    @(posedge pixel_clk);
    model_step(!arstn, enable, vs, vde, rgb, ack, exp_crc_v);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".valid"},   32'(sig_valid),      32'(e_valid));
    check_val({tag, ".crc"},     sig_crc,             e_crc);
    check_val({tag, ".pix"},     32'(sig_pix_count),  32'(e_pix));
    check_val({tag, ".lines"},   32'(sig_line_count), 32'(e_lines));
    check_val({tag, ".geom"},    32'(sig_geom_err),   32'(e_geom));
    check_val({tag, ".overrun"}, 32'(sig_overrun),    32'(e_overrun));
    check_val({tag, ".fcount"},  32'(frame_count),    32'(e_fc));
`ifdef VIDEO_FRAME_SIGNATURE_COMPARE_EN
    check_val({tag, ".match"},   32'(sig_match),      32'(e_match));
`endif
  endtask

  function automatic logic [11:0] pix_word(input int pat, input int idx);
    case (pat)
      0:       return 12'hFFF;
      1:       return 12'(idx);
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic send_line(input int len, input int pat, inout int idx);
    for (int p = 0; p < len; p++) begin
      apply_stimulus(1'b1, 1'b1, pix_word(pat, idx), 1'b0);
      idx++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b1, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic send_frame(input int len0, input int len1, input int pat);
    int idx;
    idx = 0;
    idle_cycles(2);
    send_line(len0, pat, idx);
    idle_cycles(2);
    send_line(len1, pat, idx);
    idle_cycles(2);
  endtask

  typedef struct {
    int len0;
    int len1;
    int pat;
    bit flip;
    int exp_pix;
    int exp_lines;
    bit exp_geom;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] crc_hist[6];

  initial begin
    tbl[0] = '{4, 4, 0, 1'b0, 8, 2, 1'b0};
    tbl[1] = '{4, 4, 1, 1'b0, 8, 2, 1'b0};
    tbl[2] = '{4, 4, 1, 1'b1, 8, 2, 1'b0};
    tbl[3] = '{4, 3, 0, 1'b0, 7, 2, 1'b1};
    tbl[4] = '{4, 4, 2, 1'b0, 8, 2, 1'b0};
    tbl[5] = '{3, 4, 2, 1'b1, 7, 2, 1'b1};

    arstn     = 1'b0;
    enable    = 1'b1;
    exp_crc_v = 32'h0;
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 1'b0, 12'h000, 1'b0);
    check_output("reset");
    check_val("reset.valid0", 32'(sig_valid), 32'd0);
    check_val("reset.crc0", sig_crc, 32'd0);

    arstn = 1'b1;
    idle_cycles(2);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
    check_val("arm.novalid", 32'(sig_valid), 32'd0);
    check_output("arm");

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].len0, tbl[i].len1, tbl[i].pat);
      exp_crc_v = model_crc() ^ {31'd0, tbl[i].flip};
      crc_hist[i] = model_crc();
      apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
      check_output($sformatf("tbl%0d", i));
      check_val($sformatf("tbl%0d.valid1", i), 32'(sig_valid), 32'd1);
      check_val($sformatf("tbl%0d.pixc", i), 32'(sig_pix_count), 32'(tbl[i].exp_pix));
      check_val($sformatf("tbl%0d.linec", i), 32'(sig_line_count), 32'(tbl[i].exp_lines));
      check_val($sformatf("tbl%0d.geomc", i), 32'(sig_geom_err), 32'(tbl[i].exp_geom));
`ifdef VIDEO_FRAME_SIGNATURE_COMPARE_EN
      check_val($sformatf("tbl%0d.matchc", i), 32'(sig_match), 32'(!tbl[i].flip));
`endif
      if (i == 0) check_val("tbl0.fcount1", 32'(frame_count), 32'd1);
      if (i == 2) check_val("tbl2.repeat_crc", sig_crc, crc_hist[1]);
      apply_stimulus(1'b1, 1'b0, 12'h000, 1'b1);
      check_val($sformatf("tbl%0d.ackclr", i), 32'(sig_valid), 32'd0);
      check_output($sformatf("tbl%0d.ack", i));
    end

    // Close and acknowledge in the same cycle: new result, no overrun.
    send_frame(4, 4, 2);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
    check_output("sameack.first");
    send_frame(4, 4, 2);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b1);
    check_val("sameack.valid", 32'(sig_valid), 32'd1);
    check_val("sameack.overrun", 32'(sig_overrun), 32'd0);
    check_output("sameack");
    apply_stimulus(1'b1, 1'b0, 12'h000, 1'b1);
    check_output("sameack.ack");

    // Pixel on the frame-edge cycle opens the new frame.
    send_frame(4, 4, 1);
    apply_stimulus(1'b0, 1'b1, 12'h5A5, 1'b0);
    check_output("edgepix.prev");
    check_val("edgepix.prevpix", 32'(sig_pix_count), 32'd8);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b1, 12'($urandom), 1'b0);
    idle_cycles(2);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 1'b1, 12'($urandom), 1'b0);
    idle_cycles(2);
    apply_stimulus(1'b1, 1'b0, 12'h000, 1'b1);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
    check_val("edgepix.pix", 32'(sig_pix_count), 32'd8);
    check_val("edgepix.geom", 32'(sig_geom_err), 32'd0);
    check_output("edgepix");
    apply_stimulus(1'b1, 1'b0, 12'h000, 1'b1);

    // Dropping enable mid-frame discards it; the next edge only re-arms.
    idle_cycles(2);
    apply_stimulus(1'b1, 1'b1, 12'h123, 1'b0);
    enable = 1'b0;
    idle_cycles(2);
    enable = 1'b1;
    idle_cycles(2);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
    check_val("enable.rearm", 32'(sig_valid), 32'd0);
    check_output("enable.rearm");
    send_frame(4, 4, 2);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
    check_output("enable.frame");
    apply_stimulus(1'b1, 1'b0, 12'h000, 1'b1);

    // Reset mid-frame, then re-arm and overrun with two unacknowledged closes.
    idle_cycles(2);
    apply_stimulus(1'b1, 1'b1, 12'h0F0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 12'h00F, 1'b0);
    arstn = 1'b0;
    idle_cycles(2);
    check_val("midrst.fcount", 32'(frame_count), 32'd0);
    check_val("midrst.pix", 32'(sig_pix_count), 32'd0);
    check_output("midrst");
    arstn = 1'b1;
    idle_cycles(2);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
    check_val("midrst.rearm", 32'(sig_valid), 32'd0);
    send_frame(4, 4, 2);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
    check_val("midrst.fcount1", 32'(frame_count), 32'd1);
    check_output("midrst.frame");
    send_frame(4, 4, 2);
    apply_stimulus(1'b0, 1'b0, 12'h000, 1'b0);
    check_val("overrun.flag", 32'(sig_overrun), 32'd1);
    check_val("overrun.fcount", 32'(frame_count), 32'd2);
    check_output("overrun");
    apply_stimulus(1'b1, 1'b0, 12'h000, 1'b1);
    check_val("overrun.ackclr", 32'(sig_valid), 32'd0);
    check_val("overrun.sticky", 32'(sig_overrun), 32'd1);
    check_output("overrun.ack");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
